// File: rtl/led_shift_driver.sv
// LED shift-register driver.
//
// Watches a 16-bit LED pattern. When it differs from the pattern last shown on the external
// chain, it captures the pattern and shifts it out serially. It then pulses a storage-register
// latch so that all 16 outputs of the external chain update together.
//
// Parameters
//   CLK_DIV   : clk cycles per sclk half-period (1..255)
//   MSB_FIRST : 1 = LEDs[15] shifted first, 0 = LEDs[0] shifted first
//
// Ports
//   clk   : system clock, all state updates on its rising edge
//   rst   : asynchronous active-low reset
//   LEDs  : LED pattern from the flasher stage
//   sdo   : serial data; held stable across each sclk high phase
//   sclk  : serial shift clock; the external device samples sdo on its rising edge
//   latch : storage-register strobe, one CLK_DIV-long pulse per frame
//   busy  : high for the whole 33*CLK_DIV-cycle frame transfer
module led_shift_driver #(
  parameter int unsigned CLK_DIV   = 2,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] LEDs,
  output logic        sdo,
  output logic        sclk,
  output logic        latch,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StShiftLo, StShiftHi, StLatch} state_e;

  localparam logic [7:0] DivLast  = 8'(CLK_DIV - 1);
  localparam logic [3:0] FirstIdx = MSB_FIRST ? 4'd15 : 4'd0;

  state_e      state_q, state_d;
  logic [15:0] frame_q, frame_d;
  logic [15:0] shown_q, shown_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  div_cnt_q, div_cnt_d;
  logic        sdo_q, sdo_d;
  logic        sclk_q, sclk_d;
  logic        latch_q, latch_d;
  logic        busy_q, busy_d;

  logic        div_last;
  logic [3:0]  bit_cnt_inc;
  logic [3:0]  next_idx;

  assign div_last    = (div_cnt_q == DivLast);
  assign bit_cnt_inc = bit_cnt_q + 4'd1;
  // For MSB-first the index counts down: 15 - n is the bitwise inverse of n in 4 bits.
  assign next_idx    = MSB_FIRST ? ~bit_cnt_inc : bit_cnt_inc;

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    shown_d   = shown_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    sdo_d     = sdo_q;

    unique case (state_q)
      StIdle: begin
        sdo_d = 1'b0;
        if (LEDs != shown_q) begin
          frame_d   = LEDs;
          bit_cnt_d = 4'd0;
          div_cnt_d = 8'd0;
          // The first bit comes straight from LEDs because frame_q is not loaded yet.
          sdo_d     = LEDs[FirstIdx];
          state_d   = StShiftLo;
        end
      end
      StShiftLo: begin
        if (div_last) begin
          div_cnt_d = 8'd0;
          state_d   = StShiftHi;
        end else begin
          div_cnt_d = div_cnt_q + 8'd1;
        end
      end
      StShiftHi: begin
        if (div_last) begin
          div_cnt_d = 8'd0;
          if (bit_cnt_q == 4'd15) begin
            sdo_d   = 1'b0;
            state_d = StLatch;
          end else begin
            bit_cnt_d = bit_cnt_inc;
            // sdo moves only as sclk falls, so it is stable for the whole high phase.
            sdo_d     = frame_q[next_idx];
            state_d   = StShiftLo;
          end
        end else begin
          div_cnt_d = div_cnt_q + 8'd1;
        end
      end
      StLatch: begin
        sdo_d = 1'b0;
        if (div_last) begin
          div_cnt_d = 8'd0;
          shown_d   = frame_q;
          state_d   = StIdle;
        end else begin
          div_cnt_d = div_cnt_q + 8'd1;
        end
      end
    endcase
  end

  // Strobes are decoded from the next state and registered, so they line up with state_q.
  always_comb begin
    sclk_d  = (state_d == StShiftHi);
    latch_d = (state_d == StLatch);
    busy_d  = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      frame_q   <= 16'h0000;
      shown_q   <= 16'h0000;
      bit_cnt_q <= 4'd0;
      div_cnt_q <= 8'd0;
      sdo_q     <= 1'b0;
      sclk_q    <= 1'b0;
      latch_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      shown_q   <= shown_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      sdo_q     <= sdo_d;
      sclk_q    <= sclk_d;
      latch_q   <= latch_d;
      busy_q    <= busy_d;
    end
  end

  assign sdo   = sdo_q;
  assign sclk  = sclk_q;
  assign latch = latch_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_led_shift_driver.sv
// Directed bench for led_shift_driver: an MSB-first instance (a) and an LSB-first instance (b),
// both with CLK_DIV = 2.
module tb_led_shift_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] leds_a, leds_b;
  logic        sdo_a, sclk_a, latch_a, busy_a;
  logic        sdo_b, sclk_b, latch_b, busy_b;

  always #5 clk = ~clk;

  led_shift_driver #(.CLK_DIV(2), .MSB_FIRST(1'b1)) dut_a (
    .clk   (clk),
    .rst   (rst),
    .LEDs  (leds_a),
    .sdo   (sdo_a),
    .sclk  (sclk_a),
    .latch (latch_a),
    .busy  (busy_a)
  );

  led_shift_driver #(.CLK_DIV(2), .MSB_FIRST(1'b0)) dut_b (
    .clk   (clk),
    .rst   (rst),
    .LEDs  (leds_b),
    .sdo   (sdo_b),
    .sclk  (sclk_b),
    .latch (latch_b),
    .busy  (busy_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Results of the most recent observed frame.
  int          f_wait, f_len, f_rises, f_latch, f_bad_latch, f_glitch;
  logic [15:0] f_bits;
  logic        f_latch_after;

  // Called on a negedge. Waits (bounded) for busy, then samples every negedge while busy.
  // Bits are assembled in transmission order, first bit ending up in f_bits[15].
  task automatic run_frame(input bit sel, input int max_wait);
    logic b, s, d, l;
    logic prev_s, prev_d;
    prev_s = 1'b0;
    prev_d = 1'b0;
    f_wait = 0; f_len = 0; f_rises = 0; f_latch = 0; f_bad_latch = 0; f_glitch = 0;
    f_bits = 16'h0000;
    b = sel ? busy_b : busy_a;
    while (!b && f_wait < max_wait) begin
      @(negedge clk);
      f_wait++;
      b = sel ? busy_b : busy_a;
    end
    while (b && f_len < 200) begin
      s = sel ? sclk_b : sclk_a;
      d = sel ? sdo_b : sdo_a;
      l = sel ? latch_b : latch_a;
      f_len++;
      if (s && !prev_s) begin
        f_bits = {f_bits[14:0], d};
        f_rises++;
      end
      if (s && prev_s && d !== prev_d) f_glitch++;
      if (l) begin
        f_latch++;
        if (f_rises != 16) f_bad_latch++;
      end
      prev_s = s;
      prev_d = d;
      @(negedge clk);
      b = sel ? busy_b : busy_a;
    end
    f_latch_after = sel ? latch_b : latch_a;
  endtask

  task automatic test_reset();
    int act;
    rst = 1'b0;
    leds_a = 16'h0000;
    leds_b = 16'h0000;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({sdo_a, sclk_a, latch_a, busy_a} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_outs_a: got %b want 0000", {sdo_a, sclk_a, latch_a, busy_a});
    end
    n_cmp++;
    if ({sdo_b, sclk_b, latch_b, busy_b} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_outs_b: got %b want 0000", {sdo_b, sclk_b, latch_b, busy_b});
    end
    rst = 1'b1;
    act = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ({sdo_a, sclk_a, latch_a, busy_a, sdo_b, sclk_b, latch_b, busy_b} !== 8'h00) act++;
    end
    n_cmp++;
    if (act != 0) begin
      n_bad++;
      $display("FAIL idle_quiet: got %0d active cycles want 0", act);
    end
  endtask

  task automatic test_msb_first();
    leds_a = 16'h8001;
    run_frame(1'b0, 10);
    n_cmp++;
    if (f_wait != 1) begin
      n_bad++; $display("FAIL msb_start: got %0d want 1", f_wait);
    end
    n_cmp++;
    if (f_len != 66) begin
      n_bad++; $display("FAIL msb_busy_len: got %0d want 66", f_len);
    end
    n_cmp++;
    if (f_rises != 16) begin
      n_bad++; $display("FAIL msb_rises: got %0d want 16", f_rises);
    end
    n_cmp++;
    if (f_bits !== 16'h8001) begin
      n_bad++; $display("FAIL msb_bits: got %h want 8001", f_bits);
    end
    n_cmp++;
    if (f_latch != 2 || f_bad_latch != 0) begin
      n_bad++; $display("FAIL msb_latch: got %0d/%0d early want 2/0", f_latch, f_bad_latch);
    end
    n_cmp++;
    if (f_glitch != 0) begin
      n_bad++; $display("FAIL msb_sdo_stable: got %0d changes want 0", f_glitch);
    end
    n_cmp++;
    if (f_latch_after !== 1'b0) begin
      n_bad++; $display("FAIL msb_latch_end: got %b want 0", f_latch_after);
    end
  endtask

  task automatic test_lsb_first();
    leds_b = 16'h0003;
    run_frame(1'b1, 10);
    n_cmp++;
    if (f_bits !== 16'hC000) begin
      n_bad++; $display("FAIL lsb_bits: got %h want c000", f_bits);
    end
    n_cmp++;
    if (f_rises != 16 || f_len != 66) begin
      n_bad++; $display("FAIL lsb_shape: got %0d rises %0d busy want 16/66", f_rises, f_len);
    end
    n_cmp++;
    if (f_latch != 2 || f_bad_latch != 0) begin
      n_bad++; $display("FAIL lsb_latch: got %0d/%0d early want 2/0", f_latch, f_bad_latch);
    end
  endtask

  task automatic test_back_to_back();
    leds_a = 16'h0001;
    fork
      run_frame(1'b0, 10);
      begin
        repeat (11) @(negedge clk);
        leds_a = 16'h0003;
      end
    join
    n_cmp++;
    if (f_bits !== 16'h0001 || f_len != 66) begin
      n_bad++; $display("FAIL b2b_first: got %h/%0d want 0001/66", f_bits, f_len);
    end
    run_frame(1'b0, 10);
    n_cmp++;
    if (f_wait != 1) begin
      n_bad++; $display("FAIL b2b_gap: got %0d want 1", f_wait);
    end
    n_cmp++;
    if (f_bits !== 16'h0003 || f_len != 66 || f_latch != 2) begin
      n_bad++;
      $display("FAIL b2b_second: got %h/%0d/%0d want 0003/66/2", f_bits, f_len, f_latch);
    end
  endtask

  task automatic test_revert();
    leds_a = 16'h00FF;
    fork
      run_frame(1'b0, 10);
      begin
        repeat (11) @(negedge clk);
        leds_a = 16'h0000;
      end
    join
    n_cmp++;
    if (f_bits !== 16'h00FF || f_len != 66) begin
      n_bad++; $display("FAIL revert_first: got %h/%0d want 00ff/66", f_bits, f_len);
    end
    run_frame(1'b0, 10);
    n_cmp++;
    if (f_wait != 1 || f_bits !== 16'h0000 || f_len != 66 || f_latch != 2) begin
      n_bad++;
      $display("FAIL revert_zero: got wait %0d bits %h len %0d latch %0d want 1/0000/66/2",
               f_wait, f_bits, f_len, f_latch);
    end
    run_frame(1'b0, 50);
    n_cmp++;
    if (f_len != 0) begin
      n_bad++; $display("FAIL revert_quiet: got %0d busy cycles want 0", f_len);
    end
  endtask

  task automatic test_reset_abort();
    int lat;
    leds_a = 16'hFFFF;
    repeat (21) @(negedge clk);
    n_cmp++;
    if (busy_a !== 1'b1) begin
      n_bad++; $display("FAIL abort_busy_before: got %b want 1", busy_a);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({sdo_a, sclk_a, latch_a, busy_a} !== 4'b0000) begin
      n_bad++; $display("FAIL abort_immediate: got %b want 0000", {sdo_a, sclk_a, latch_a, busy_a});
    end
    lat = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (latch_a !== 1'b0 || busy_a !== 1'b0) lat++;
    end
    n_cmp++;
    if (lat != 0) begin
      n_bad++; $display("FAIL abort_hold: got %0d active cycles want 0", lat);
    end
    rst = 1'b1;
    run_frame(1'b0, 10);
    n_cmp++;
    if (f_wait != 1) begin
      n_bad++; $display("FAIL abort_restart: got %0d want 1", f_wait);
    end
    n_cmp++;
    if (f_bits !== 16'hFFFF || f_len != 66 || f_rises != 16 || f_latch != 2) begin
      n_bad++;
      $display("FAIL abort_frame: got %h/%0d/%0d/%0d want ffff/66/16/2",
               f_bits, f_len, f_rises, f_latch);
    end
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_back_to_back();
    test_revert();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
